sr_flag_scheduler: RTL and testbench
====================================

Name: sr_flag_scheduler

Overview:
- Arbitrates a bank of NFLAGS set/reset (SR) flag bits among NREQ requesters.
- Grants at most one set, clear or hold operation per clock, using round-robin priority.
- Traps the forbidden S=R=1 combination and out-of-range indices as errors, so a flag never goes undefined.
- Provides a sequenced clear-all sweep. Sits between control agents and the shared status-flag bank.

Parameters:
- NREQ, 4, number of requesters (2..8).
- NFLAGS, 8, number of SR flag bits.
- IDXW, 3, flag index width; must satisfy 2**IDXW >= NFLAGS.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_op  in  2*NREQ  per-requester {s,r}: 00 hold, 01 clear, 10 set, 11 illegal. Requester i uses bits [2i+1:2i].
- req_idx  in  IDXW*NREQ  per-requester target flag index.
- req_ready  out  NREQ  one-hot grant, combinational, same cycle as the accepted valid.
- clr_all  in  1  single-cycle pulse requesting a clear-all sweep.
- flags  out  NFLAGS  registered flag bank.
- busy  out  1  high while the sweep runs.
- err  out  1  one-cycle pulse on an illegal request.
- err_id  out  3  requester number of the last error; holds until the next error.

Behaviour:
- Reset (async assert, sync release): flags=0, FSM=IDLE, rr pointer=0, err=0, err_id=0, busy=0, req_ready=0.
- FSM states: IDLE and SWEEP.

IDLE:
- If clr_all=1: no grant that cycle (req_ready=0), go to SWEEP with sweep counter=0. clr_all beats any request.
- Otherwise, grant the first requester with req_valid=1, searching from index ptr upward with wrap at NREQ.
- Handshake completes when valid and ready are both high in the same cycle. The requester holds op and idx stable until granted. Ungranted requesters wait with no timeout.
- After a grant to k, ptr becomes (k+1) mod NREQ. With no grant, ptr is unchanged.
- Granted op, applied at that rising edge and visible on flags the next cycle:
  - 10: flags[idx]=1.
  - 01: flags[idx]=0.
  - 00: flags unchanged; still counts as a grant and advances ptr.
  - 11: flags unchanged; err=1 on the next cycle; err_id=k.
- idx >= NFLAGS with any op: flags unchanged, err pulse, err_id=k. The request is still granted and consumed.

SWEEP:
- busy=1 and req_ready=0 for the whole sweep.
- Each cycle clears flags[cnt], then cnt increments.
- After clearing index NFLAGS-1, return to IDLE; busy drops the following cycle.
- Duration is exactly NFLAGS cycles in SWEEP.
- clr_all during SWEEP is ignored; the sweep does not restart.

General rules:
- Flags not addressed hold their value; exactly one flag changes per cycle at most.
- ptr wraps from NREQ-1 to 0.
- Reset asserted mid-sweep or mid-request aborts immediately to the reset values. No partial sweep state survives.
- err is never asserted for two consecutive cycles unless two consecutive grants are both illegal.

Test Plan:
- Set then clear: after reset, req0 asserts op=10, idx=3 → ready0=1 same cycle, flags=0x08 next cycle. Then req0 op=01, idx=3 → flags=0x00.
- Round-robin fairness: all four requesters valid continuously with op=10 and idx=0,1,2,3 → grants in order 0,1,2,3, one per cycle; flags=0x0F after 4 cycles; ptr back to 0.
- Forbidden op: req2 op=11, idx=5 while flags=0x20 → ready2=1, flags stays 0x20, err pulses 1 cycle later with err_id=2. Index 9 with NFLAGS=8 gives the same err response.
- Clear-all priority: flags=0xFF, clr_all and req1 (op=10) in the same cycle → ready1=0, busy=1 for 8 cycles, flags=0x00 after sweep. req1 is granted on the first IDLE cycle, and flags then shows its bit set.
- Reset mid-sweep: rst_n=0 at sweep cycle 4 with flags=0xF0 → flags=0, busy=0, FSM=IDLE immediately. After release, req3 is granted before req1 only if ptr rules dictate (ptr=0 → req1 first).
- Hold op: req0 op=00 with flags=0x55 → granted, flags remains 0x55, no err, ptr advances to 1.

Source files
------------

// File: rtl/sr_flag_scheduler.sv
// sr_flag_scheduler
//   Round-robin arbiter that grants one requester per clock access to a shared
//   bank of set/reset flag bits. It also runs a sequenced clear-all sweep.
//   Requests with the forbidden S=R=1 op, or with an index past the bank, are
//   granted and consumed without touching the bank. Instead they raise a
//   one-cycle err pulse and record the requester number in err_id.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req_valid  per-requester request valid           [NREQ]
//   req_op     per-requester {s,r} op, 2 bits each    [2*NREQ]
//   req_idx    per-requester flag index, IDXW each    [IDXW*NREQ]
//   req_ready  one-hot combinational grant            [NREQ]
//   clr_all    single-cycle pulse starting a clear-all sweep
//   flags      registered flag bank                   [NFLAGS]
//   busy       high while the sweep runs
//   err        one-cycle pulse after an illegal grant
//   err_id     requester number of the most recent illegal grant
module sr_flag_scheduler #(
  parameter int NREQ   = 4,
  parameter int NFLAGS = 8,
  parameter int IDXW   = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [2*NREQ-1:0]      req_op,
  input  logic [IDXW*NREQ-1:0]   req_idx,
  output logic [NREQ-1:0]        req_ready,
  input  logic                   clr_all,
  output logic [NFLAGS-1:0]      flags,
  output logic                   busy,
  output logic                   err,
  output logic [2:0]             err_id
);

  localparam logic [0:0]      ST_IDLE  = 1'b0;
  localparam logic [0:0]      ST_SWEEP = 1'b1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NFLAGS - 1);
  localparam logic [2:0]      LAST_REQ = 3'(NREQ - 1);

  logic [0:0]        state_reg;
  logic [2:0]        ptr_reg;
  logic [IDXW-1:0]   cnt_reg;
  logic [NFLAGS-1:0] flags_reg;
  logic [NFLAGS-1:0] flags_next;
  logic              err_reg;
  logic [2:0]        err_id_reg;

  logic [NREQ-1:0]   upper_mask;
  logic [NREQ-1:0]   upper_req;
  logic              grant_any;
  logic [2:0]        grant_id;
  logic [1:0]        grant_op;
  logic [IDXW-1:0]   grant_idx;
  logic              idx_in_range;
  logic              grant_bad;
  logic              write_en;
  logic [2:0]        ptr_next;

  // Requesters at or above the pointer get first pick. The unmasked vector
  // is the wrap-around fallback.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_mask
      assign upper_mask[gi] = (3'(gi) >= ptr_reg);
      assign req_ready[gi]  = grant_any && (grant_id == 3'(gi));
    end
  endgenerate

  assign upper_req = req_valid & upper_mask;

  always_comb begin
    grant_any = 1'b0;
    grant_id  = 3'd0;
    for (int i = 0; i < NREQ; i++) begin
      if (!grant_any && upper_req[i]) begin
        grant_any = 1'b1;
        grant_id  = 3'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!grant_any && req_valid[i]) begin
        grant_any = 1'b1;
        grant_id  = 3'(i);
      end
    end
    // No grants while reset is applied, during the sweep, or when clr_all wins.
    if (!rst_n || state_reg != ST_IDLE || clr_all) begin
      grant_any = 1'b0;
    end
  end

  always_comb begin
    grant_op  = 2'b00;
    grant_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_id == 3'(i)) begin
        grant_op  = req_op[2*i +: 2];
        grant_idx = req_idx[IDXW*i +: IDXW];
      end
    end
  end

  assign idx_in_range = (32'(grant_idx) < NFLAGS);
  assign grant_bad    = grant_any && (!idx_in_range || grant_op == 2'b11);
  assign write_en     = grant_any && idx_in_range &&
                        (grant_op == 2'b10 || grant_op == 2'b01);
  assign ptr_next     = (grant_id == LAST_REQ) ? 3'd0 : grant_id + 3'd1;

  // At most one bit changes per cycle. A grant and a sweep never coincide,
  // so the two hit terms are mutually exclusive.
  generate
    for (genvar gi = 0; gi < NFLAGS; gi++) begin : g_flag
      logic sweep_hit;
      logic write_hit;
      assign sweep_hit = (state_reg == ST_SWEEP) && (cnt_reg == IDXW'(gi));
      assign write_hit = write_en && (grant_idx == IDXW'(gi));
      assign flags_next[gi] = sweep_hit ? 1'b0 :
                              write_hit ? grant_op[1] : flags_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      ptr_reg    <= 3'd0;
      cnt_reg    <= '0;
      flags_reg  <= '0;
      err_reg    <= 1'b0;
      err_id_reg <= 3'd0;
    end else begin
      flags_reg <= flags_next;
      err_reg   <= grant_bad;
      if (grant_bad) begin
        err_id_reg <= grant_id;
      end
      if (grant_any) begin
        ptr_reg <= ptr_next;
      end
      case (state_reg)
        ST_IDLE: begin
          if (clr_all) begin
            state_reg <= ST_SWEEP;
            cnt_reg   <= '0;
          end
        end
        ST_SWEEP: begin
          // clr_all is ignored here, so the sweep never restarts.
          if (cnt_reg == LAST_IDX) begin
            state_reg <= ST_IDLE;
          end else begin
            cnt_reg <= cnt_reg + IDXW'(1);
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign flags  = flags_reg;
  assign busy   = (state_reg == ST_SWEEP);
  assign err    = err_reg;
  assign err_id = err_id_reg;

endmodule

// File: tb/tb_sr_flag_scheduler.sv
module tb_sr_flag_scheduler;

  localparam int NREQ   = 4;
  localparam int NFLAGS = 8;
  localparam int IDXW   = 4;

  logic                 clk;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [2*NREQ-1:0]    req_op;
  logic [IDXW*NREQ-1:0] req_idx;
  logic [NREQ-1:0]      req_ready;
  logic                 clr_all;
  logic [NFLAGS-1:0]    flags;
  logic                 busy;
  logic                 err;
  logic [2:0]           err_id;

  int n_checks = 0;
  int n_fail   = 0;

  sr_flag_scheduler #(.NREQ(NREQ), .NFLAGS(NFLAGS), .IDXW(IDXW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op),
    .req_idx(req_idx), .req_ready(req_ready), .clr_all(clr_all),
    .flags(flags), .busy(busy), .err(err), .err_id(err_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_req(input int k, input logic [1:0] op, input logic [IDXW-1:0] idx);
    req_valid[k]           = 1'b1;
    req_op[2*k +: 2]       = op;
    req_idx[IDXW*k +: IDXW] = idx;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; req_valid = '0; req_op = '0; req_idx = '0; clr_all = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  // Setup-only transaction: a single requester, granted on this edge.
  task automatic txn(input int k, input logic [1:0] op, input logic [IDXW-1:0] idx);
    set_req(k, op, idx);
    step();
    req_valid[k] = 1'b0;
    $display("txn req%0d op=%b idx=%0d flags=%h", k, op, idx, flags);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = '0; req_op = '0; req_idx = '0; clr_all = 1'b0;
    step();
    set_req(0, 2'b10, 4'd1);
    #1;
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b want %b", req_ready, 4'b0000); end
    n_checks++; if (flags !== 8'h00) begin n_fail++; $display("FAIL reset_flags: got %h want %h", flags, 8'h00); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (err !== 1'b0 || err_id !== 3'd0) begin n_fail++; $display("FAIL reset_err: got %b/%0d want 0/0", err, err_id); end
    req_valid = '0;
    step();
    rst_n = 1'b1;
    step();
    $display("txn reset released");
  endtask

  task automatic test_set_clear();
    set_req(0, 2'b10, 4'd3);
    #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL set_ready: got %b want %b", req_ready, 4'b0001); end
    step(); req_valid = '0;
    n_checks++; if (flags !== 8'h08) begin n_fail++; $display("FAIL set_flags: got %h want %h", flags, 8'h08); end
    $display("txn set req0 idx3 flags=%h", flags);
    set_req(0, 2'b01, 4'd3);
    #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL clear_ready: got %b want %b", req_ready, 4'b0001); end
    step(); req_valid = '0;
    n_checks++; if (flags !== 8'h00) begin n_fail++; $display("FAIL clear_flags: got %h want %h", flags, 8'h00); end
    $display("txn clear req0 idx3 flags=%h", flags);
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0]   exp_ready;
    logic [NFLAGS-1:0] exp_flags;
    apply_reset();
    for (int k = 0; k < NREQ; k++) set_req(k, 2'b10, 4'(k));
    exp_flags = 8'h00;
    for (int j = 0; j < NREQ; j++) begin
      #1;
      exp_ready = 4'b0001 << j;
      n_checks++; if (req_ready !== exp_ready) begin n_fail++; $display("FAIL rr_grant%0d: got %b want %b", j, req_ready, exp_ready); end
      step();
      req_valid[j] = 1'b0;
      exp_flags[j] = 1'b1;
      n_checks++; if (flags !== exp_flags) begin n_fail++; $display("FAIL rr_flags%0d: got %h want %h", j, flags, exp_flags); end
      $display("txn rr grant req%0d flags=%h", j, flags);
    end
    // Pointer is back at 0: req0 beats req3.
    set_req(0, 2'b00, 4'd0); set_req(3, 2'b00, 4'd0);
    #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rr_wrap: got %b want %b", req_ready, 4'b0001); end
    step(); req_valid[0] = 1'b0;
    #1;
    n_checks++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL rr_wait3: got %b want %b", req_ready, 4'b1000); end
    step(); req_valid = '0;
    $display("txn rr wrap flags=%h", flags);
  endtask

  task automatic test_forbidden();
    apply_reset();
    txn(0, 2'b10, 4'd5);
    set_req(2, 2'b11, 4'd5);
    #1;
    n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL illegal_ready: got %b want %b", req_ready, 4'b0100); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL illegal_err_early: got %b want 0", err); end
    step(); req_valid = '0;
    n_checks++; if (flags !== 8'h20) begin n_fail++; $display("FAIL illegal_flags: got %h want %h", flags, 8'h20); end
    n_checks++; if (err !== 1'b1 || err_id !== 3'd2) begin n_fail++; $display("FAIL illegal_err: got %b/%0d want 1/2", err, err_id); end
    $display("txn illegal op req2 err=%b err_id=%0d", err, err_id);
    step();
    n_checks++; if (err !== 1'b0 || err_id !== 3'd2) begin n_fail++; $display("FAIL err_pulse: got %b/%0d want 0/2", err, err_id); end
    // ptr is now 3, so req1 is reached after 3 and 0.
    set_req(1, 2'b10, 4'd9);
    #1;
    n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL range_ready: got %b want %b", req_ready, 4'b0010); end
    step(); req_valid = '0;
    n_checks++; if (flags !== 8'h20) begin n_fail++; $display("FAIL range_flags: got %h want %h", flags, 8'h20); end
    n_checks++; if (err !== 1'b1 || err_id !== 3'd1) begin n_fail++; $display("FAIL range_err: got %b/%0d want 1/1", err, err_id); end
    $display("txn out-of-range req1 err=%b err_id=%0d", err, err_id);
    step();
  endtask

  task automatic test_clear_all();
    logic [NFLAGS-1:0] exp_flags;
    apply_reset();
    for (int b = 0; b < NFLAGS; b++) txn(0, 2'b10, 4'(b));
    n_checks++; if (flags !== 8'hFF) begin n_fail++; $display("FAIL sweep_preload: got %h want %h", flags, 8'hFF); end
    clr_all = 1'b1;
    set_req(1, 2'b10, 4'd6);
    #1;
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL clr_priority: got %b want %b", req_ready, 4'b0000); end
    step();
    clr_all = 1'b0;
    for (int j = 0; j < NFLAGS; j++) begin
      exp_flags = 8'hFF;
      exp_flags = exp_flags << j;
      n_checks++; if (busy !== 1'b1 || req_ready !== 4'b0000) begin n_fail++; $display("FAIL sweep_busy%0d: got busy=%b ready=%b want 1/0000", j, busy, req_ready); end
      n_checks++; if (flags !== exp_flags) begin n_fail++; $display("FAIL sweep_flags%0d: got %h want %h", j, flags, exp_flags); end
      clr_all = (j == 3);
      step();
      clr_all = 1'b0;
    end
    n_checks++; if (busy !== 1'b0 || flags !== 8'h00) begin n_fail++; $display("FAIL sweep_done: got busy=%b flags=%h want 0/00", busy, flags); end
    n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL sweep_regrant: got %b want %b", req_ready, 4'b0010); end
    step(); req_valid = '0;
    n_checks++; if (flags !== 8'h40) begin n_fail++; $display("FAIL sweep_after: got %h want %h", flags, 8'h40); end
    $display("txn clear-all then req1 flags=%h", flags);
  endtask

  task automatic test_reset_mid_sweep();
    apply_reset();
    for (int b = 4; b < NFLAGS; b++) txn(0, 2'b10, 4'(b));
    n_checks++; if (flags !== 8'hF0) begin n_fail++; $display("FAIL midrst_preload: got %h want %h", flags, 8'hF0); end
    clr_all = 1'b1;
    step();
    clr_all = 1'b0;
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    n_checks++; if (flags !== 8'h00 || busy !== 1'b0) begin n_fail++; $display("FAIL midrst_state: got flags=%h busy=%b want 00/0", flags, busy); end
    rst_n = 1'b1;
    set_req(1, 2'b00, 4'd0); set_req(3, 2'b00, 4'd0);
    #1;
    n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL midrst_ptr: got %b want %b", req_ready, 4'b0010); end
    step(); req_valid[1] = 1'b0;
    #1;
    n_checks++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL midrst_next: got %b want %b", req_ready, 4'b1000); end
    step(); req_valid = '0;
    $display("txn reset mid-sweep flags=%h", flags);
  endtask

  task automatic test_hold();
    apply_reset();
    for (int k = 0; k < NREQ; k++) txn(k, 2'b10, 4'(2*k));
    set_req(0, 2'b00, 4'd2);
    #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL hold_ready: got %b want %b", req_ready, 4'b0001); end
    step(); req_valid = '0;
    n_checks++; if (flags !== 8'h55 || err !== 1'b0) begin n_fail++; $display("FAIL hold_flags: got flags=%h err=%b want 55/0", flags, err); end
    set_req(0, 2'b00, 4'd0); set_req(1, 2'b00, 4'd0);
    #1;
    n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL hold_ptr: got %b want %b", req_ready, 4'b0010); end
    step(); req_valid = '0;
    $display("txn hold req0 flags=%h", flags);
  endtask

  initial begin
    test_reset();
    test_set_clear();
    test_round_robin();
    test_forbidden();
    test_clear_all();
    test_reset_mid_sweep();
    test_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
